// File: rtl/daq_conv_sched.sv
// rtl/daq_conv_sched.sv - ADC conversion scheduler and sample stream framer
// Purpose: periodic conversion tick, conversion-start pulse, busy handshake
//          with timeout guard, then NCH-word CS/RD readout presented one word
//          at a time on a valid/ready stream.
// Ports:   clk_i, reset_i      clock, asynchronous active-low reset
//          en_i, div_i         enable and period-minus-one of the tick counter
//          clr_i               clears overrun_o / timeout_o
//          busy_i, adc_data_i  from the ADC (busy_i is asynchronous)
//          conv_o, cs_no, rd_no to the ADC
//          sample_o, chan_o, last_o, valid_o, ready_i  sample stream
//          active_o, overrun_o, timeout_o              status
module daq_conv_sched #(
   parameter int DIV_W   = 16,
   parameter int NCH     = 8,
   parameter int CONV_W  = 4,
   parameter int RD_W    = 3,
   parameter int TIMEOUT = 255,
   localparam int CH_W   = $clog2(NCH)
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             en_i,
   input  logic [DIV_W-1:0] div_i,
   input  logic             clr_i,
   input  logic             busy_i,
   input  logic [15:0]      adc_data_i,
   output logic             conv_o,
   output logic             cs_no,
   output logic             rd_no,
   output logic [15:0]      sample_o,
   output logic [CH_W-1:0]  chan_o,
   output logic             last_o,
   output logic             valid_o,
   input  logic             ready_i,
   output logic             active_o,
   output logic             overrun_o,
   output logic             timeout_o
);

   // One shared phase counter serves the CONV width, the RD low width and
   // the busy timeouts, so it is sized for the largest of the three.
   localparam int T_MAX = (TIMEOUT > CONV_W) ? ((TIMEOUT > RD_W) ? TIMEOUT : RD_W)
                                             : ((CONV_W > RD_W) ? CONV_W : RD_W);
   localparam int TC_W  = $clog2(T_MAX + 1);
   localparam logic [TC_W-1:0] CONV_LAST = TC_W'(CONV_W - 1);
   localparam logic [TC_W-1:0] RD_LAST   = TC_W'(RD_W - 1);
   localparam logic [TC_W-1:0] TO_LAST   = TC_W'(TIMEOUT - 1);
   localparam logic [CH_W-1:0] CH_LAST   = CH_W'(NCH - 1);

   typedef enum logic [2:0] {IDLE, CONV, WAIT_HI, WAIT_LO, RD_WAIT, RD_LO} state_t;

   state_t           state, state_nxt;
   logic [DIV_W-1:0] cnt;
   logic             tick;
   logic             busy_m, busy_s;
   logic [TC_W-1:0]  tcnt, tcnt_nxt;
   logic [CH_W-1:0]  idx, idx_nxt;
   logic             load;
   logic             to_set;

   // >= rather than == so a div_i lowered mid-count still reloads promptly.
   assign tick     = en_i && (cnt >= div_i);
   assign active_o = (state != IDLE);

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         busy_m <= 1'b0;
         busy_s <= 1'b0;
      end else begin
         busy_m <= busy_i;
         busy_s <= busy_m;
      end
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i)
         cnt <= '0;
      else if (!en_i || tick)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

   always_comb begin
      state_nxt = state;
      tcnt_nxt  = tcnt + 1'b1;
      idx_nxt   = idx;
      load      = 1'b0;
      to_set    = 1'b0;
      conv_o    = 1'b0;
      cs_no     = 1'b1;
      rd_no     = 1'b1;
      unique case (state)
         IDLE: begin
            tcnt_nxt = '0;
            if (tick)
               state_nxt = CONV;
         end
         CONV: begin
            conv_o = 1'b1;
            if (tcnt == CONV_LAST) begin
               state_nxt = WAIT_HI;
               tcnt_nxt  = '0;
            end
         end
         WAIT_HI: begin
            if (busy_s) begin
               state_nxt = WAIT_LO;
               tcnt_nxt  = '0;
            end else if (tcnt == TO_LAST) begin
               state_nxt = IDLE;
               to_set    = 1'b1;
            end
         end
         WAIT_LO: begin
            if (!busy_s) begin
               state_nxt = RD_WAIT;
               tcnt_nxt  = '0;
               idx_nxt   = '0;
            end else if (tcnt == TO_LAST) begin
               state_nxt = IDLE;
               to_set    = 1'b1;
            end
         end
         RD_WAIT: begin
            // Only strobe when the captured word has somewhere to go, so no
            // word of the frame can ever be overwritten.
            cs_no    = 1'b0;
            tcnt_nxt = '0;
            if (!valid_o || ready_i)
               state_nxt = RD_LO;
         end
         RD_LO: begin
            cs_no = 1'b0;
            rd_no = 1'b0;
            if (tcnt == RD_LAST) begin
               load     = 1'b1;
               tcnt_nxt = '0;
               if (idx == CH_LAST) begin
                  state_nxt = IDLE;
               end else begin
                  idx_nxt   = idx + 1'b1;
                  state_nxt = RD_WAIT;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state     <= IDLE;
         tcnt      <= '0;
         idx       <= '0;
         sample_o  <= '0;
         chan_o    <= '0;
         last_o    <= 1'b0;
         valid_o   <= 1'b0;
         overrun_o <= 1'b0;
         timeout_o <= 1'b0;
      end else begin
         state <= state_nxt;
         tcnt  <= tcnt_nxt;
         idx   <= idx_nxt;
         // A reload on the handshake edge keeps valid_o high.
         if (load) begin
            sample_o <= adc_data_i;
            chan_o   <= idx;
            last_o   <= (idx == CH_LAST);
            valid_o  <= 1'b1;
         end else if (ready_i) begin
            valid_o <= 1'b0;
         end
         if (tick && (state != IDLE))
            overrun_o <= 1'b1;
         else if (clr_i)
            overrun_o <= 1'b0;
         if (to_set)
            timeout_o <= 1'b1;
         else if (clr_i)
            timeout_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_daq_conv_sched.sv
// tb/tb_daq_conv_sched.sv - randomized self-checking bench for daq_conv_sched
module tb_daq_conv_sched;
   localparam int DIV_W   = 16;
   localparam int NCH     = 8;
   localparam int CONV_W  = 4;
   localparam int RD_W    = 3;
   localparam int TIMEOUT = 255;
   localparam int CH_W    = $clog2(NCH);

   logic             clk_i = 1'b0;
   logic             reset_i = 1'b0;
   logic             en_i = 1'b0;
   logic [DIV_W-1:0] div_i = '0;
   logic             clr_i = 1'b0;
   logic             busy_i = 1'b0;
   logic [15:0]      adc_data_i = '0;
   logic             ready_i = 1'b0;
   logic             conv_o, cs_no, rd_no, last_o, valid_o, active_o, overrun_o, timeout_o;
   logic [15:0]      sample_o;
   logic [CH_W-1:0]  chan_o;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   // ADC model state
   int          bt = 0, bwait = 0, blen = 0;
   bit          busy_stuck = 0;
   int          busy_fixed = 0;
   logic [7:0]  frame_id = 8'hFF;
   int          rd_k = 0, rd_falls = 0;
   bit          conv_prev = 0, rd_prev = 1;
   logic [19:0] exp_q[$];

   // consumer / monitor state
   int          conv_len = 0, rd_len = 0, conv_rises = 0, n_words = 0;
   bit          hold_pend = 0;
   logic [15:0] held;
   logic [19:0] e;
   bit          rdy_rand = 0, rdy_force = 1;

   daq_conv_sched #(.DIV_W(DIV_W), .NCH(NCH), .CONV_W(CONV_W), .RD_W(RD_W), .TIMEOUT(TIMEOUT)) dut (
      .clk_i(clk_i), .reset_i(reset_i), .en_i(en_i), .div_i(div_i), .clr_i(clr_i),
      .busy_i(busy_i), .adc_data_i(adc_data_i), .conv_o(conv_o), .cs_no(cs_no), .rd_no(rd_no),
      .sample_o(sample_o), .chan_o(chan_o), .last_o(last_o), .valid_o(valid_o), .ready_i(ready_i),
      .active_o(active_o), .overrun_o(overrun_o), .timeout_o(timeout_o));

   always #5 clk_i = ~clk_i;

   initial forever begin
      @(posedge clk_i);
      cyc++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   task automatic wait_conv(input int maxc, output int t);
      bit p;
      int k;
      p = conv_o;
      t = -1;
      k = 0;
      while (t < 0 && k < maxc) begin
         step(1);
         k++;
         if (conv_o && !p) t = cyc;
         p = conv_o;
      end
      check("conv_seen", 32'(t >= 0), 1);
   endtask

   task automatic wait_drain(input int maxc);
      int k;
      k = 0;
      while ((active_o || valid_o) && k < maxc) begin
         step(1);
         k++;
      end
      check("drain", 32'(active_o || valid_o), 0);
   endtask

   task automatic clr_pulse();
      clr_i = 1'b1;
      step(1);
      clr_i = 1'b0;
   endtask

   // ADC: busy pulse after each conversion start; the k-th RD falling edge of
   // a frame presents channel k, which is what must later leave the stream.
   initial forever begin
      @(posedge clk_i);
      #1;
      if (!reset_i) begin
         bt = 0;
         busy_i = 1'b0;
         conv_prev = 0;
         rd_prev = 1;
         rd_k = 0;
      end else begin
         if (conv_o && !conv_prev) begin
            frame_id++;
            rd_k = 0;
            if (!busy_stuck) begin
               bt = 1;
               bwait = $urandom_range(1, 3);
               blen = (busy_fixed != 0) ? busy_fixed : $urandom_range(3, 40);
            end
         end else if (bt != 0) begin
            bt++;
         end
         busy_i = (bt > bwait) && (bt <= bwait + blen);
         if (bt > bwait + blen) bt = 0;
         if (!rd_no && rd_prev) begin
            adc_data_i = {4'hA, frame_id, 4'(rd_k)};
            exp_q.push_back({adc_data_i, CH_W'(rd_k), 1'(rd_k == NCH - 1)});
            rd_k++;
            rd_falls++;
         end else if (rd_no && !rd_prev) begin
            adc_data_i = 16'($urandom);
         end
         conv_prev = conv_o;
         rd_prev = rd_no;
      end
   end

   initial forever begin
      @(posedge clk_i);
      #2;
      ready_i = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
   end

   // Consumer side: scoreboard, stall stability and strobe widths.
   initial forever begin
      @(negedge clk_i);
      if (!reset_i) begin
         conv_len = 0;
         rd_len = 0;
         hold_pend = 0;
      end else begin
         if (hold_pend) begin
            check("hold_valid", 32'(valid_o), 1);
            check("hold_data", 32'(sample_o), 32'(held));
            hold_pend = 0;
         end
         if (valid_o && ready_i) begin
            n_words++;
            check("sb_nonempty", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("word", 32'({sample_o, chan_o, last_o}), 32'(e));
            end
         end else if (valid_o) begin
            hold_pend = 1;
            held = sample_o;
         end
         if (conv_o) begin
            if (conv_len == 0) conv_rises++;
            conv_len++;
         end else if (conv_len != 0) begin
            check("conv_width", 32'(conv_len), CONV_W);
            conv_len = 0;
         end
         if (!rd_no) begin
            check("rd_needs_cs", 32'(cs_no), 0);
            rd_len++;
         end else if (rd_len != 0) begin
            check("rd_width", 32'(rd_len), RD_W);
            rd_len = 0;
         end
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, t1, t2, w0, c0, r0, n;
      bit p;

      step(3);
      check("rst_conv", 32'(conv_o), 0);
      check("rst_cs", 32'(cs_no), 1);
      check("rst_rd", 32'(rd_no), 1);
      check("rst_sample", 32'(sample_o), 0);
      check("rst_chan", 32'(chan_o), 0);
      check("rst_last", 32'(last_o), 0);
      check("rst_valid", 32'(valid_o), 0);
      check("rst_active", 32'(active_o), 0);
      check("rst_overrun", 32'(overrun_o), 0);
      check("rst_timeout", 32'(timeout_o), 0);
      reset_i = 1'b1;
      step(2);

      // basic periodic frames
      div_i = 16'd999;
      en_i = 1'b1;
      t0 = cyc;
      wait_conv(1100, t1);
      check("first_tick", 32'(t1 - t0), 1000);
      wait_conv(1100, t2);
      check("period", 32'(t2 - t1), 1000);
      w0 = n_words;
      wait_conv(1100, t1);
      check("period2", 32'(t1 - t2), 1000);
      check("words_per_frame", 32'(n_words - w0), NCH);
      check("basic_overrun", 32'(overrun_o), 0);
      check("basic_timeout", 32'(timeout_o), 0);

      // back-pressure on word 2 of the frame just started
      n = 0;
      while (!(valid_o && chan_o == CH_W'(2)) && n < 300) begin
         step(1);
         n++;
      end
      check("bp_word2_seen", 32'(valid_o && chan_o == CH_W'(2)), 1);
      rdy_force = 0;
      repeat (50) begin
         step(1);
         check("bp_rd_high", 32'(rd_no), 1);
         check("bp_cs_low", 32'(cs_no), 0);
         check("bp_chan", 32'(chan_o), 2);
      end
      rdy_force = 1;
      en_i = 1'b0;
      wait_drain(600);
      check("bp_sb_empty", 32'(exp_q.size()), 0);

      // randomized period, busy and ready
      rdy_rand = 1;
      div_i = 16'($urandom_range(250, 400));
      w0 = n_words;
      c0 = conv_rises;
      en_i = 1'b1;
      repeat (5) wait_conv(500, t1);
      en_i = 1'b0;
      wait_drain(800);
      check("rnd_words", 32'(n_words - w0), 32'(NCH * (conv_rises - c0)));
      check("rnd_overrun", 32'(overrun_o), 0);
      check("rnd_timeout", 32'(timeout_o), 0);
      rdy_rand = 0;

      // overrun: period shorter than the frame
      busy_fixed = 40;
      div_i = 16'd20;
      w0 = n_words;
      en_i = 1'b1;
      wait_conv(100, t1);
      step(20);
      check("ovr_before", 32'(overrun_o), 0);
      step(1);
      check("ovr_set", 32'(overrun_o), 1);
      check("ovr_active", 32'(active_o), 1);
      en_i = 1'b0;
      wait_drain(500);
      check("ovr_frame_words", 32'(n_words - w0), NCH);
      clr_pulse();
      check("ovr_clr", 32'(overrun_o), 0);
      en_i = 1'b1;
      wait_conv(100, t1);
      step(20);
      check("ovr_before2", 32'(overrun_o), 0);
      clr_i = 1'b1;
      step(1);
      clr_i = 1'b0;
      check("ovr_set_beats_clr", 32'(overrun_o), 1);
      en_i = 1'b0;
      wait_drain(500);
      busy_fixed = 0;
      clr_pulse();

      // timeout: busy never rises
      busy_stuck = 1;
      div_i = 16'd999;
      en_i = 1'b1;
      wait_conv(1100, t1);
      r0 = rd_falls;
      step(CONV_W + TIMEOUT - 1);
      check("to_before", 32'(timeout_o), 0);
      check("to_active", 32'(active_o), 1);
      step(1);
      check("to_set", 32'(timeout_o), 1);
      check("to_idle", 32'(active_o), 0);
      check("to_no_rd", 32'(rd_falls - r0), 0);
      busy_stuck = 0;
      w0 = n_words;
      wait_conv(1100, t2);
      check("to_next_tick", 32'(t2 - t1), 1000);
      en_i = 1'b0;
      wait_drain(500);
      check("to_next_words", 32'(n_words - w0), NCH);
      clr_pulse();
      check("to_clr", 32'(timeout_o), 0);

      // reset during channel 4 read strobe
      div_i = 16'd50;
      en_i = 1'b1;
      wait_conv(100, t1);
      n = 0;
      p = 1;
      r0 = 0;
      while (n < 5 && r0 < 400) begin
         step(1);
         r0++;
         if (!rd_no && p) n++;
         p = rd_no;
      end
      check("mid_ch4_reached", 32'(n), 5);
      reset_i = 1'b0;
      #1;
      check("mr_conv", 32'(conv_o), 0);
      check("mr_cs", 32'(cs_no), 1);
      check("mr_rd", 32'(rd_no), 1);
      check("mr_valid", 32'(valid_o), 0);
      check("mr_sample", 32'(sample_o), 0);
      check("mr_chan", 32'(chan_o), 0);
      check("mr_active", 32'(active_o), 0);
      step(2);
      exp_q.delete();
      reset_i = 1'b1;
      t0 = cyc;
      w0 = n_words;
      wait_conv(200, t1);
      check("mr_first_tick", 32'(t1 - t0), 51);
      en_i = 1'b0;
      wait_drain(500);
      check("mr_frame_words", 32'(n_words - w0), NCH);

      // en_i dropped mid-frame
      div_i = 16'd200;
      en_i = 1'b1;
      wait_conv(300, t1);
      w0 = n_words;
      step(5);
      en_i = 1'b0;
      wait_drain(500);
      check("endrop_words", 32'(n_words - w0), NCH);
      c0 = conv_rises;
      step(600);
      check("endrop_no_conv", 32'(conv_rises - c0), 0);

      check("sb_empty", 32'(exp_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/daq_conv_sched.md
# daq_conv_sched

Conversion scheduler for the multichannel DAQ ADC front end. It generates a programmable-rate conversion tick and drives the ADC conversion-start pulse, with a busy-timeout guard. It then reads NCH parallel 16-bit words through CS/RD strobes and presents them one at a time on a valid/ready sample stream toward the capture logic. It replaces free-running conversion clocking with a fully sequenced, back-pressure-aware frame controller in the fast clock domain.

## Interface
- DIV_W, 16: width of sample-period divider
- NCH, 8: channels read per conversion frame (2..16)
- CONV_W, 4: conv_o high width in clk cycles (>=1)
- RD_W, 3: rd_no low width in clk cycles (>=1)
- TIMEOUT, 255: max cycles waited per busy edge
- clk_i  in  1  single clock (fast DCM clock)
- reset_i  in  1  asynchronous, active-low reset
- en_i  in  1  enable periodic scheduling
- div_i  in  DIV_W  sample period minus 1, in clk cycles
- clr_i  in  1  clear sticky flags
- busy_i  in  1  ADC busy, asynchronous; 2-flop synchronized internally (busy_s)
- adc_data_i  in  16  ADC parallel data bus
- conv_o  out  1  conversion start, active high
- cs_no  out  1  ADC chip select, active low
- rd_no  out  1  ADC read strobe, active low
- sample_o  out  16  captured word
- chan_o  out  $clog2(NCH)  channel index of sample_o
- last_o  out  1  sample_o is channel NCH-1
- valid_o  in/out: out  1  sample_o valid
- ready_i  in  1  consumer accepts when valid_o&&ready_i
- active_o  out  1  frame in progress (state != IDLE)
- overrun_o  out  1  sticky: tick arrived while frame active
- timeout_o  out  1  sticky: busy edge not seen within TIMEOUT

## Operation
- Tick counter: while en_i=1, counts 0..div_i, tick=1 on the cycle cnt==div_i, then reloads 0. en_i=0 holds cnt at 0, no ticks; a frame in progress completes normally.
- States: IDLE, CONV, WAIT_HI, WAIT_LO, RD_WAIT, RD_LO.
- IDLE: tick -> CONV. tick in any other state -> overrun_o=1, tick dropped.
- CONV: conv_o=1 for exactly CONV_W cycles -> WAIT_HI.
- WAIT_HI: busy_s=1 -> WAIT_LO. TIMEOUT cycles without it -> timeout_o=1, IDLE.
- WAIT_LO: busy_s=0 -> RD_WAIT, channel index=0. Same TIMEOUT rule, with a fresh count.
- RD_WAIT: cs_no=0, rd_no=1. Proceed to RD_LO only when output slot free (valid_o=0 or ready_i=1 this cycle). Otherwise stall indefinitely; no timeout.
- RD_LO: cs_no=0, rd_no=0 for RD_W cycles. On the clock edge ending the last low cycle: sample_o<=adc_data_i, chan_o<=index, last_o<=(index==NCH-1), valid_o<=1. If index==NCH-1 -> IDLE (cs_no=1); else index+1 -> RD_WAIT.
- valid_o clears on handshake unless reloaded on the same edge; reload wins.
- Sticky flags: clr_i clears both; simultaneous set and clr -> flag set.
- Words within a frame are never dropped or overwritten; back-pressure only stretches the frame.

## Timing
- Reset (async assert, synchronous-release): state IDLE, cnt 0, conv_o 0, cs_no 1, rd_no 1, sample_o 0, chan_o 0, last_o 0, valid_o 0, active_o 0, overrun_o 0, timeout_o 0. Reset mid-frame abandons the frame immediately.
- First tick occurs div_i+1 cycles after en_i rises; period is div_i+1 cycles.
- conv_o rises the cycle after the tick.
- busy_i to busy_s latency: 2 cycles.
- rd_no is high at least 1 cycle between strobes (RD_WAIT).
- valid_o rises the same cycle rd_no returns high.
- Minimum frame with no stall: 1 + CONV_W + busy time + 4 sync cycles + NCH*(RD_W+1).
- div_i=0: tick every cycle; overrun_o sets in the first frame.

## Test plan
- Basic frame: NCH=8, div_i=999, ready_i=1, busy model high 3..40 cycles after conv_o; data=0xA000+ch -> 8 words 0xA000..0xA007, chan 0..7, last_o only on ch7, frames every 1000 cycles, no flags set.
- Back-pressure: ready_i low 50 cycles after word 2 -> rd_no held high, cs_no low, word 2 stable; all 8 words delivered in order, none lost.
- Overrun: div_i=20 with busy 40 cycles -> overrun_o=1 at the first tick inside the frame, frame still completes. clr_i then clears the flag; clr_i coincident with a new overrun leaves it set.
- Timeout: busy_i stuck 0 -> timeout_o=1 exactly TIMEOUT cycles after WAIT_HI entry, state IDLE, no rd_no strobes; next tick starts a new frame.
- Reset mid-read: assert reset_i=0 during ch 4 RD_LO -> all outputs take reset values asynchronously; after release with en_i=1, the first tick comes div_i+1 cycles later and the frame starts at ch 0.
- en_i drop mid-frame: the frame finishes all NCH words, then no further conv_o pulses occur.
